// File: rtl/add_approx_pipe.sv
// Two-stage approximate/exact adder pipeline with valid/ready handshakes
// on both sides and saturating error statistics on the output side.
// In approximate mode the low K bits are formed by a carry-free OR, and
// the upper bits add without any carry in from that low field.
module add_approx_pipe #(
  parameter int W  = 8,
  parameter int K  = 1,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    out_sum,
  output logic [W-1:0]  out_err,
  input  logic          stat_clr,
  output logic [CW-1:0] stat_txn,
  output logic [CW-1:0] stat_errs,
  output logic [CW-1:0] stat_abs,
  output logic [W-1:0]  stat_max
);

  // Low-field mask; a 64-bit shift keeps K == W == 32 well defined.
  localparam logic [W-1:0] LOW_MASK = W'((64'd1 << K) - 64'd1);
  // Accumulator width wide enough that stat_abs + out_err cannot overflow.
  localparam int SW = ((CW > W) ? CW : W) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CW{1'b1}});

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          s1_mode;
  logic          s2_load;
  logic          s1_adv;
  logic          out_xfer;

  logic [W:0]    exact_sum;
  logic [W:0]    hi_sum;
  logic [W:0]    approx_sum;
  logic [W:0]    res_sum;
  logic [W-1:0]  res_err;
  logic [SW-1:0] abs_sum;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = s1_adv;
  assign out_xfer = out_valid && out_ready;

  // Masking the low field out of the operands before adding guarantees
  // that no carry crosses from bit K-1 into bit K; the sum's low bits are
  // then zero, so OR-ing in the carry-free low field is exact placement.
  assign exact_sum  = {1'b0, s1_a} + {1'b0, s1_b};
  assign hi_sum     = {1'b0, s1_a & ~LOW_MASK} + {1'b0, s1_b & ~LOW_MASK};
  assign approx_sum = hi_sum | {1'b0, (s1_a | s1_b) & LOW_MASK};
  assign res_sum    = s1_mode ? approx_sum : exact_sum;
  assign res_err    = s1_mode ? (s1_a & s1_b & LOW_MASK) : '0;

  assign abs_sum = SW'(stat_abs) + SW'(out_err);

  // Stage 1: capture operand pair and mode on an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= in_mode;
      end
    end
  end

  // Stage 2: register result; data only changes when a new item arrives,
  // so a stalled output holds its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum <= res_sum;
        out_err <= res_err;
      end
    end
  end

  // Saturating statistics over delivered results; clear wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_txn  <= '0;
      stat_errs <= '0;
      stat_abs  <= '0;
      stat_max  <= '0;
    end else if (stat_clr) begin
      stat_txn  <= '0;
      stat_errs <= '0;
      stat_abs  <= '0;
      stat_max  <= '0;
    end else if (out_xfer) begin
      if (stat_txn != {CW{1'b1}}) stat_txn <= stat_txn + CW'(1);
      if ((out_err != '0) && (stat_errs != {CW{1'b1}}))
        stat_errs <= stat_errs + CW'(1);
      stat_abs <= (abs_sum > CNT_MAX) ? {CW{1'b1}} : abs_sum[CW-1:0];
      if (out_err > stat_max) stat_max <= out_err;
    end
  end

endmodule

// File: tb/tb_add_approx_pipe.sv
// Directed bench for add_approx_pipe: one instance with K=1/CW=4 and one
// with K=4/CW=16 share the same stimulus.
module tb_add_approx_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready4;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_mode = 1'b0;
  logic        out_valid, out_valid4;
  logic        out_ready = 1'b1;
  logic [8:0]  out_sum, out_sum4;
  logic [7:0]  out_err, out_err4;
  logic        stat_clr = 1'b0;
  logic [3:0]  stat_txn, stat_errs, stat_abs;
  logic [7:0]  stat_max;
  logic [15:0] stat_txn4, stat_errs4, stat_abs4;
  logic [7:0]  stat_max4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  add_approx_pipe #(.W(8), .K(1), .CW(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .stat_clr(stat_clr),
    .stat_txn(stat_txn), .stat_errs(stat_errs), .stat_abs(stat_abs),
    .stat_max(stat_max)
  );

  add_approx_pipe #(.W(8), .K(4), .CW(16)) u_dut_k4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_sum(out_sum4), .out_err(out_err4), .stat_clr(stat_clr),
    .stat_txn(stat_txn4), .stat_errs(stat_errs4), .stat_abs(stat_abs4),
    .stat_max(stat_max4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic mode, input logic [8:0] es, input logic [7:0] ee,
                          input logic [8:0] es4, input logic [7:0] ee4, input logic clr);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},   32'(out_sum),   32'(es));
    chk({tag, "_err"},   32'(out_err),   32'(ee));
    chk({tag, "_sum4"},  32'(out_sum4),  32'(es4));
    chk({tag, "_err4"},  32'(out_err4),  32'(ee4));
    stat_clr = clr;
    step();
    stat_clr = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  logic [8:0] exp_q [5];
  int sent, recv, outs;

  initial begin
    // Reset state while rst is held
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_stat_txn",  32'(stat_txn),  32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors: K=1 expectations, then K=4 expectations
    send_one("ap_01_01", 8'h01, 8'h01, 1'b1, 9'h001, 8'h01, 9'h001, 8'h01, 1'b0);
    send_one("ex_01_01", 8'h01, 8'h01, 1'b0, 9'h002, 8'h00, 9'h002, 8'h00, 1'b0);
    send_one("ap_ff_ff", 8'hFF, 8'hFF, 1'b1, 9'h1FD, 8'h01, 9'h1EF, 8'h0F, 1'b0);
    send_one("ex_ff_ff", 8'hFF, 8'hFF, 1'b0, 9'h1FE, 8'h00, 9'h1FE, 8'h00, 1'b0);
    send_one("ap_0f_33", 8'h0F, 8'h33, 1'b1, 9'h041, 8'h01, 9'h03F, 8'h03, 1'b0);
    chk("st_txn",  32'(stat_txn),  32'd5);
    chk("st_errs", 32'(stat_errs), 32'd3);
    chk("st_abs",  32'(stat_abs),  32'd3);
    chk("st_max",  32'(stat_max),  32'd1);
    chk("st_abs4", 32'(stat_abs4), 32'd19);
    chk("st_max4", 32'(stat_max4), 32'd15);

    // Clear coincident with an output transfer: delivered, not counted
    send_one("clr_xfer", 8'h21, 8'h10, 1'b0, 9'h031, 8'h00, 9'h031, 8'h00, 1'b1);
    chk("clr_txn",  32'(stat_txn),  32'd0);
    chk("clr_errs", 32'(stat_errs), 32'd0);
    chk("clr_abs",  32'(stat_abs),  32'd0);
    chk("clr_max",  32'(stat_max),  32'd0);
    chk("clr_txn4", 32'(stat_txn4), 32'd0);

    // Saturation: 20 erroneous back-to-back transfers into 4-bit counters
    outs = 0;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i == 20) in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) outs++;
      step();
    end
    chk("sat_outs",  32'(outs),      32'd20);
    chk("sat_txn",   32'(stat_txn),  32'd15);
    chk("sat_errs",  32'(stat_errs), 32'd15);
    chk("sat_abs",   32'(stat_abs),  32'd15);
    chk("sat_max",   32'(stat_max),  32'd1);
    chk("sat_txn4",  32'(stat_txn4), 32'd20);

    // Back-pressure: 5 transfers, out_ready low in cycles 3..5
    for (int i = 0; i < 5; i++) exp_q[i] = 9'(i + 1) + 9'h010;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 5);
      in_a      = 8'(sent + 1);
      in_b      = 8'h10;
      in_mode   = 1'b0;
      #1;
      if (cyc == 3) chk("bp_in_ready_drop", 32'(in_ready), 32'd0);
      if (cyc >= 3 && cyc <= 5) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_sum",   32'(out_sum),   32'(exp_q[recv]));
      end
      if (out_valid && out_ready) begin
        if (recv < 5) chk("bp_order", 32'(out_sum), 32'(exp_q[recv]));
        else chk("bp_extra", 32'(recv), 32'd4);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
      if (sent == 5 && recv == 5) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd5);
    chk("bp_recv", 32'(recv), 32'd5);

    // Reset with two results in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h40; in_b = 8'h02; in_mode = 1'b0;
    step();
    in_a = 8'h50;
    step();
    in_valid = 1'b0;
    chk("mid_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum",   32'(out_sum),   32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) outs++;
      step();
    end
    chk("mid_no_stale", 32'(outs), 32'd0);
    chk("mid_stat_txn", 32'(stat_txn), 32'd0);
    send_one("post_rst", 8'h12, 8'h34, 1'b0, 9'h046, 8'h00, 9'h046, 8'h00, 1'b0);
    chk("post_rst_txn", 32'(stat_txn), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/add_approx_pipe.md
ADD_APPROX_PIPE -- requirements
Module: add_approx_pipe

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand width in bits (legal 2..32).
REQ-002 The block SHALL have parameter K, default 1, meaning the number of approximated low bits (legal 0..W).
REQ-003 The block SHALL have parameter CW, default 16, meaning the width of each statistics counter (legal 4..32).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-009 The block SHALL have ports in_a and in_b, input, W bits each: operands, unsigned.
REQ-010 The block SHALL have port in_mode, input, 1 bit: 0 selects exact add, 1 selects approximate add.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port out_sum, output, W+1 bits: the result.
REQ-014 The block SHALL have port out_err, output, W bits: exact sum minus out_sum, zero-extended.
REQ-015 The block SHALL have port stat_clr, input, 1 bit: synchronous clear of all statistics.
REQ-016 The block SHALL have ports stat_txn, stat_errs and stat_abs, output, CW bits each, and stat_max, output, W bits.

Function
REQ-017 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_a, in_b and in_mode are captured together.
REQ-018 Approximate result: bits K-1..0 = in_a|in_b per bit; carry into bit K = 0; bits W..K = exact sum of the operand bits W-1..K.
REQ-019 Exact result SHALL be in_a+in_b over W+1 bits; error SHALL equal (in_a & in_b) masked to bits K-1..0 in approx mode, 0 in exact mode or when K=0.
REQ-020 The datapath SHALL be a two-stage pipeline: stage 1 registers operands and mode, stage 2 registers out_sum and out_err; latency SHALL be exactly 2 cycles from input transfer to out_valid, with no stall.
REQ-021 Throughput SHALL be one transfer per cycle while out_ready=1.
REQ-022 Stage 2 SHALL load when empty or out_ready=1; stage 1 SHALL advance when empty or stage 2 loads; in_ready SHALL be 1 exactly when stage 1 is empty or advancing.
REQ-023 While out_valid=1 and out_ready=0, out_sum and out_err SHALL hold stable; no result SHALL be dropped or duplicated.
REQ-024 On each output transfer (out_valid & out_ready), stat_txn +1, stat_errs +1 if out_err!=0, stat_abs += out_err, and stat_max = max(stat_max, out_err).
REQ-025 All statistics counters SHALL saturate at 2^CW-1 and never wrap.
REQ-026 stat_clr=1 SHALL zero all statistics at the edge; a coincident output transfer SHALL still complete but SHALL NOT be counted.
REQ-027 Statistics SHALL NOT affect the datapath; pipeline contents SHALL be unaffected by stat_clr.

Reset
REQ-028 rst=1 SHALL immediately force out_valid=0, in_ready=1 (after release), out_sum=0, out_err=0, all stage valids=0, and all statistics=0, regardless of clock.
REQ-029 Reset asserted mid-operation SHALL discard both in-flight results; the first transfer after release SHALL appear 2 cycles later.

Verification
REQ-030 The bench SHALL apply W=8, K=1, approx, a=0x01, b=0x01 -> out_sum=0x001, out_err=0x01; in exact mode -> out_sum=0x002, out_err=0.
REQ-031 The bench SHALL apply a=0xFF, b=0xFF in approx mode -> out_sum=0x1FD, out_err=0x01; with K=4 -> out_sum=0x1EF, out_err=0x0F.
REQ-032 The bench SHALL stream 5 back-to-back transfers with out_ready held 0 for cycles 3-5 -> in_ready drops once both stages are full, results emerge in order, and none are lost.
REQ-033 The bench SHALL use CW=4 and 20 erroneous transfers -> stat_txn=15, stat_errs=15, stat_abs=15, with no wrap.
REQ-034 The bench SHALL assert stat_clr coincident with an output transfer -> all statistics are 0 on the next cycle and the result is still delivered.
REQ-035 The bench SHALL assert rst with 2 results in flight -> out_valid=0 immediately, and no stale result appears after release.
